// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: up or up/down counter, period boundary detect and
// commit of the shadowed period/mode into the active registers.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] pend_period,
    input  logic             pend_mode,
    output logic [WIDTH-1:0] counter,
    output logic [WIDTH-1:0] period_act,
    output logic             boundary_c,
    output logic             commit_c
);

    dir_e             dir, dir_nxt;
    logic             mode_act, mode_nxt;
    logic [WIDTH-1:0] counter_nxt, period_nxt, last_c;

    // Top count value; guarded so an empty period never underflows.
    assign last_c = (period_act != '0) ? (period_act - WIDTH'(1)) : '0;

    always_comb begin
        boundary_c = 1'b0;
        if (period_act == '0) begin
            boundary_c = 1'b1;
        end else if (mode_act == MODE_CENTER) begin
            boundary_c = (dir == DIR_DOWN) && (counter == '0);
        end else begin
            boundary_c = (counter == last_c);
        end
    end

    assign commit_c = boundary_c || !enable;

    // Every period (and every disabled cycle) restarts from the valley going up.
    always_comb begin
        counter_nxt = counter;
        dir_nxt     = dir;
        period_nxt  = period_act;
        mode_nxt    = mode_act;
        if (commit_c) begin
            period_nxt = pend_period;
            mode_nxt   = pend_mode;
        end
        if (!enable || boundary_c) begin
            counter_nxt = '0;
            dir_nxt     = DIR_UP;
        end else if (mode_act == MODE_EDGE) begin
            counter_nxt = counter + WIDTH'(1);
        end else if (dir == DIR_UP) begin
            if (counter == last_c) begin
                dir_nxt = DIR_DOWN;
            end else begin
                counter_nxt = counter + WIDTH'(1);
            end
        end else begin
            counter_nxt = counter - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter    <= '0;
            dir        <= DIR_UP;
            period_act <= '0;
            mode_act   <= MODE_EDGE;
        end else begin
            counter    <= counter_nxt;
            dir        <= dir_nxt;
            period_act <= period_nxt;
            mode_act   <= mode_nxt;
        end
    end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator on one shared timebase with double-buffered
// period/duty registers committed at period boundaries.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter  int unsigned WIDTH    = 32,
    parameter  int unsigned CHANNELS = 4,
    localparam int unsigned SEL_W    = sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                center_mode,
    input  logic [WIDTH-1:0]    period,
    input  logic                period_wr,
    input  logic                duty_wr,
    input  logic [SEL_W-1:0]    duty_sel,
    input  logic [WIDTH-1:0]    duty,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start,
    output logic                update_pend
);

    logic [WIDTH-1:0]    pend_period;
    logic                pend_mode;
    logic [WIDTH-1:0]    pend_duty [CHANNELS];
    logic [WIDTH-1:0]    duty_act  [CHANNELS];
    logic [WIDTH-1:0]    counter, period_act;
    logic                boundary_c, commit_c, write_c;
    logic [CHANNELS-1:0] sel_hit_c, pwm_nxt_c;

    pwm_timebase #(
        .WIDTH (WIDTH)
    ) u_timebase (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pend_period (pend_period),
        .pend_mode   (pend_mode),
        .counter     (counter),
        .period_act  (period_act),
        .boundary_c  (boundary_c),
        .commit_c    (commit_c)
    );

    // Per-channel select decode and compare; out-of-range selects hit nothing.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign sel_hit_c[i] = duty_wr && (duty_sel == SEL_W'(i));
        assign pwm_nxt_c[i] = enable && (period_act != '0) && (counter < duty_act[i]);
    end

    assign write_c = period_wr || (|sel_hit_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_period <= '0;
            pend_mode   <= MODE_EDGE;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                pend_duty[i] <= '0;
            end
        end else begin
            if (period_wr) begin
                pend_period <= period;
                pend_mode   <= center_mode;
            end
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (sel_hit_c[i]) begin
                    pend_duty[i] <= duty;
                end
            end
        end
    end

    // Active duties take the pre-write pending value on a commit cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                duty_act[i] <= '0;
            end
        end else if (commit_c) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                duty_act[i] <= pend_duty[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
            update_pend  <= 1'b0;
        end else begin
            pwm_out      <= pwm_nxt_c;
            period_start <= enable && boundary_c;
            if (write_c) begin
                update_pend <= 1'b1;
            end else if (commit_c) begin
                update_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: vector table, directed corner
// sequences and random traffic against a period-phase reference model.
module tb_pwm_multi_channel;

    localparam int unsigned W  = 16;
    localparam int unsigned CH = 3;
    localparam int unsigned SW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          center_mode = 1'b0;
    logic [W-1:0]  period = '0;
    logic          period_wr = 1'b0;
    logic          duty_wr = 1'b0;
    logic [SW-1:0] duty_sel = '0;
    logic [W-1:0]  duty = '0;
    logic [CH-1:0] pwm_out;
    logic          period_start;
    logic          update_pend;

    always #5 clk = ~clk;

    pwm_multi_channel #(
        .WIDTH    (W),
        .CHANNELS (CH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .center_mode  (center_mode),
        .period       (period),
        .period_wr    (period_wr),
        .duty_wr      (duty_wr),
        .duty_sel     (duty_sel),
        .duty         (duty),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .update_pend  (update_pend)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: position within the current period rather than a counter/direction pair.
    int unsigned   m_p, m_d[CH], p_p, p_d[CH], pos;
    bit            m_mode, p_mode, m_upd;
    logic [CH-1:0] e_pwm;
    bit            e_ps;

    task automatic model_reset();
        m_p = 0; p_p = 0; m_mode = 0; p_mode = 0; pos = 0; m_upd = 0;
        for (int i = 0; i < CH; i++) begin
            m_d[i] = 0;
            p_d[i] = 0;
        end
    endtask

    function automatic int unsigned m_len();
        return m_mode ? 2 * m_p : m_p;
    endfunction

    function automatic int unsigned m_cnt();
        if (!m_mode || pos < m_p) return pos;
        return 2 * m_p - 1 - pos;
    endfunction

    task automatic model_step();
        bit bnd, cm, wr;
        bnd = (m_p == 0) || (pos == m_len() - 1);
        cm  = bnd || !enable;
        wr  = period_wr || (duty_wr && (int'(duty_sel) < CH));
        for (int i = 0; i < CH; i++) begin
            e_pwm[i] = enable && (m_p != 0) && (m_cnt() < m_d[i]);
        end
        e_ps = enable && bnd;
        if (wr) m_upd = 1;
        else if (cm) m_upd = 0;
        if (cm) begin
            m_p = p_p;
            m_mode = p_mode;
            for (int i = 0; i < CH; i++) m_d[i] = p_d[i];
        end
        pos = (!enable || bnd) ? 0 : pos + 1;
        if (period_wr) begin
            p_p = int'(period);
            p_mode = center_mode;
        end
        if (duty_wr && (int'(duty_sel) < CH)) p_d[duty_sel] = int'(duty);
    endtask

    // One clock: predict, clock, sample 1 time unit after the edge, drop strobes.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("model.pwm", 32'(pwm_out), 32'(e_pwm));
        check("model.period_start", 32'(period_start), 32'(e_ps));
        check("model.update_pend", 32'(update_pend), 32'(m_upd));
        period_wr = 1'b0;
        duty_wr = 1'b0;
    endtask

    task automatic wr_period(input int unsigned p, input bit mode);
        period_wr = 1'b1;
        period = W'(p);
        center_mode = mode;
    endtask

    task automatic wr_duty(input int unsigned sel, input int unsigned d);
        duty_wr = 1'b1;
        duty_sel = SW'(sel);
        duty = W'(d);
    endtask

    typedef struct {
        bit            en;
        bit            pwr;
        int unsigned   per;
        bit            dwr;
        int unsigned   sel;
        int unsigned   d;
        logic [CH-1:0] pwm;
        bit            ps;
        bit            upd;
    } vec_t;

    function automatic vec_t mk(input bit en, input bit pwr, input int unsigned per,
                                input bit dwr, input int unsigned sel, input int unsigned d,
                                input logic [CH-1:0] pwm, input bit ps, input bit upd);
        vec_t v;
        v.en = en; v.pwr = pwr; v.per = per; v.dwr = dwr; v.sel = sel; v.d = d;
        v.pwm = pwm; v.ps = ps; v.upd = upd;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        int n, hi0, hi1, hi2;

        tbl[0]  = mk(0, 1, 3, 0, 0, 0, 3'b000, 0, 1);
        tbl[1]  = mk(0, 0, 0, 1, 0, 2, 3'b000, 0, 1);
        tbl[2]  = mk(0, 0, 0, 1, 3, 5, 3'b000, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 0, 3'b001, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 3'b001, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 0, 0, 3'b000, 1, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 0, 3'b001, 0, 0);
        tbl[7]  = mk(1, 1, 1, 0, 0, 0, 3'b001, 0, 1);
        tbl[8]  = mk(1, 0, 0, 1, 1, 1, 3'b000, 1, 1);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 3'b001, 1, 0);
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 3'b011, 1, 0);
        tbl[11] = mk(1, 1, 0, 0, 0, 0, 3'b011, 1, 1);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 3'b011, 1, 0);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 3'b000, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 0);

        model_reset();
        #2;
        check("reset.pwm", 32'(pwm_out), 0);
        check("reset.period_start", 32'(period_start), 0);
        check("reset.update_pend", 32'(update_pend), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Vector table: invalid select, P=1 constant-high, P=0 all low.
        for (int i = 0; i < 15; i++) begin
            enable = tbl[i].en;
            center_mode = 1'b0;
            if (tbl[i].pwr) wr_period(tbl[i].per, 1'b0);
            if (tbl[i].dwr) wr_duty(tbl[i].sel, tbl[i].d);
            cycle();
            check("tbl.pwm", 32'(pwm_out), 32'(tbl[i].pwm));
            check("tbl.period_start", 32'(period_start), 32'(tbl[i].ps));
            check("tbl.update_pend", 32'(update_pend), 32'(tbl[i].upd));
        end

        // Edge mode P=10 with duties 3/0/10.
        enable = 1'b0;
        wr_period(10, 1'b0); cycle();
        wr_duty(0, 3); cycle();
        wr_duty(1, 0); cycle();
        wr_duty(2, 10); cycle();
        cycle();
        enable = 1'b1;
        hi0 = 0; hi1 = 0; hi2 = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            hi0 += int'(pwm_out[0]); hi1 += int'(pwm_out[1]); hi2 += int'(pwm_out[2]);
        end
        check("edge.ch0_high", hi0, 3);
        check("edge.ch1_high", hi1, 0);
        check("edge.ch2_high", hi2, 10);

        // Shadowed duty write mid-period at counter 4.
        hi0 = 0;
        for (int i = 0; i < 4; i++) begin cycle(); hi0 += int'(pwm_out[0]); end
        wr_duty(0, 7); cycle(); hi0 += int'(pwm_out[0]);
        check("shadow.pend_after_write", 32'(update_pend), 1);
        for (int i = 0; i < 5; i++) begin cycle(); hi0 += int'(pwm_out[0]); end
        check("shadow.current_period_high", hi0, 3);
        hi0 = 0;
        for (int i = 0; i < 9; i++) begin cycle(); hi0 += int'(pwm_out[0]); end
        wr_duty(0, 2); cycle(); hi0 += int'(pwm_out[0]);
        check("shadow.next_period_high", hi0, 7);
        check("shadow.pend_after_boundary_write", 32'(update_pend), 1);
        hi0 = 0;
        for (int i = 0; i < 10; i++) begin cycle(); hi0 += int'(pwm_out[0]); end
        check("shadow.boundary_write_deferred", hi0, 7);
        hi0 = 0;
        for (int i = 0; i < 10; i++) begin cycle(); hi0 += int'(pwm_out[0]); end
        check("shadow.boundary_write_applied", hi0, 2);

        // Asynchronous reset mid-count while outputs are high.
        for (int i = 0; i < 3; i++) cycle();
        wr_duty(1, 4); cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset.pwm", 32'(pwm_out), 0);
        check("async_reset.update_pend", 32'(update_pend), 0);
        check("async_reset.period_start", 32'(period_start), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();

        // Center mode P=8, D=2.
        enable = 1'b0;
        wr_period(8, 1'b1); cycle();
        wr_duty(0, 2); cycle();
        cycle();
        enable = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (!period_start && n < 40);
        check("center.first_period_len", n, 16);
        n = 0; hi0 = 0;
        do begin cycle(); n++; hi0 += int'(pwm_out[0]); end while (!period_start && n < 40);
        check("center.period_len", n, 16);
        check("center.high_cycles", hi0, 4);

        // Drop enable while high; reprogram P=6 while disabled.
        cycle();
        check("enable.high_before_drop", 32'(pwm_out[0]), 1);
        enable = 1'b0;
        cycle();
        check("enable.low_after_drop", 32'(pwm_out), 0);
        wr_period(6, 1'b0); cycle();
        cycle();
        enable = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (!period_start && n < 40);
        check("enable.first_period_len", n, 6);

        // P=1, D=1: constant high with a boundary every cycle.
        enable = 1'b0;
        wr_period(1, 1'b0); cycle();
        wr_duty(1, 1); cycle();
        cycle();
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("p1.ch1_high", 32'(pwm_out[1]), 1);
            check("p1.period_start", 32'(period_start), 1);
        end

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            if ($urandom_range(0, 19) == 0) wr_period($urandom_range(0, 12), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) wr_duty($urandom_range(0, 3), $urandom_range(0, 14));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
